// File: rtl/waveform_uart_tx_if.sv
// Control and sample-buffer read bus of the waveform UART serialiser.
// The slave modport is the serialiser; the master is the host plus capture/FIR buffer side.
interface waveform_uart_tx_if #(
  parameter int SAMPLE_W    = 14,
  parameter int NUM_SAMPLES = 1000,
  parameter int NUM_CH      = 2
);
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int ADDR_W = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1;

  // transfer control
  logic                start;
  logic                abort;
  logic [NUM_CH-1:0]   ch_mask;
  logic [15:0]         wave_number;
  logic                busy;
  logic                done;
  logic                aborted;

  // one-cycle-latency buffer read port
  logic                rd_en;
  logic [CH_W-1:0]     rd_ch;
  logic [ADDR_W-1:0]   rd_addr;
  logic [SAMPLE_W-1:0] rd_data;

  modport master (
    output start, abort, ch_mask, wave_number, rd_data,
    input  busy, done, aborted, rd_en, rd_ch, rd_addr
  );

  modport slave (
    input  start, abort, ch_mask, wave_number, rd_data,
    output busy, done, aborted, rd_en, rd_ch, rd_addr
  );
endinterface

// File: rtl/waveform_uart_tx.sv
// Streams captured waveform channels out of a sample buffer as 3-byte UART records
// (sample hi, sample lo, record index) followed by a 2-byte wave-number trailer.
module waveform_uart_tx #(
  parameter int SAMPLE_W     = 14,
  parameter int NUM_SAMPLES  = 1000,
  parameter int NUM_CH       = 2,
  parameter int CLKS_PER_BIT = 1,
  parameter int STOP_BITS    = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  waveform_uart_tx_if.slave   bus,
  output logic                uart_tx
);

  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int ADDR_W = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1;
  localparam int CNT_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  // Frame bit index: 0 = start, 1..8 = data LSB first, 9.. = stop bits.
  localparam logic [3:0]        BIT_LAST  = 4'(8 + STOP_BITS);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NUM_SAMPLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_SEND,
    S_TRAILER,
    S_DONE
  } state_t;

  state_t            state;
  logic [NUM_CH-1:0] mask_q;
  logic [15:0]       wave_q;
  logic [15:0]       sample_q;
  logic [15:0]       rec_idx;
  logic [CNT_W-1:0]  clk_cnt;
  logic [3:0]        bit_idx;
  logic [1:0]        byte_idx;
  logic              abort_pend;

  // Lowest enabled channel strictly above 'after'; MSB of the result is the found flag.
  function automatic logic [CH_W:0] next_channel(input logic [NUM_CH-1:0] mask, input int after);
    logic [CH_W:0] r;
    r = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i] && (i > after)) r = {1'b1, CH_W'(i)};
    end
    return r;
  endfunction

  logic [CH_W:0] first_ch;
  logic [CH_W:0] next_ch;
  logic [7:0]    cur_byte;
  logic [1:0]    last_byte;
  logic          next_bit;
  logic          abort_now;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    first_ch  = next_channel(bus.ch_mask, -1);
    next_ch   = next_channel(mask_q, int'(bus.rd_ch));
    cur_byte  = 8'h00;
    last_byte = 2'd2;
    if (state == S_TRAILER) begin
      last_byte = 2'd1;
      cur_byte  = (byte_idx == 2'd0) ? wave_q[15:8] : wave_q[7:0];
    end else begin
      case (byte_idx)
        2'd0:    cur_byte = sample_q[15:8];
        2'd1:    cur_byte = sample_q[7:0];
        default: cur_byte = rec_idx[7:0];
      endcase
    end
    // Level for frame bit (bit_idx + 1): a data bit while bit_idx <= 7, otherwise stop.
    next_bit  = (bit_idx >= 4'd8) ? 1'b1 : cur_byte[bit_idx[2:0]];
    abort_now = abort_pend | bus.abort;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      uart_tx     <= 1'b1;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.aborted <= 1'b0;
      bus.rd_en   <= 1'b0;
      bus.rd_ch   <= '0;
      bus.rd_addr <= '0;
      mask_q      <= '0;
      wave_q      <= '0;
      sample_q    <= '0;
      rec_idx     <= '0;
      clk_cnt     <= '0;
      bit_idx     <= '0;
      byte_idx    <= '0;
      abort_pend  <= 1'b0;
    end else begin
      bus.done    <= 1'b0;
      bus.aborted <= 1'b0;
      bus.rd_en   <= 1'b0;
      if (bus.busy && bus.abort) abort_pend <= 1'b1;

      case (state)
        S_IDLE: begin
          abort_pend <= 1'b0;
          if (bus.start) begin
            mask_q   <= bus.ch_mask;
            wave_q   <= bus.wave_number;
            rec_idx  <= '0;
            clk_cnt  <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            bus.busy <= 1'b1;
            if (first_ch[CH_W]) begin
              state       <= S_FETCH;
              bus.rd_en   <= 1'b1;
              bus.rd_ch   <= first_ch[CH_W-1:0];
              bus.rd_addr <= '0;
            end else begin
              state   <= S_TRAILER;
              uart_tx <= 1'b0;
            end
          end
        end

        S_FETCH: begin
          if (abort_now) begin
            state       <= S_IDLE;
            bus.busy    <= 1'b0;
            bus.aborted <= 1'b1;
            abort_pend  <= 1'b0;
          end else begin
            state <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (abort_now) begin
            state       <= S_IDLE;
            bus.busy    <= 1'b0;
            bus.aborted <= 1'b1;
            abort_pend  <= 1'b0;
          end else begin
            sample_q <= 16'(bus.rd_data);
            rec_idx  <= rec_idx + 16'd1;
            clk_cnt  <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            uart_tx  <= 1'b0;
            state    <= S_SEND;
          end
        end

        S_SEND, S_TRAILER: begin
          if (clk_cnt != CNT_LAST) begin
            clk_cnt <= clk_cnt + 1'b1;
          end else begin
            clk_cnt <= '0;
            if (bit_idx != BIT_LAST) begin
              bit_idx <= bit_idx + 1'b1;
              uart_tx <= next_bit;
            end else begin
              // Byte boundary: the only point where abort, record and trailer steps happen.
              bit_idx <= '0;
              if (abort_now) begin
                state       <= S_IDLE;
                uart_tx     <= 1'b1;
                bus.busy    <= 1'b0;
                bus.aborted <= 1'b1;
                abort_pend  <= 1'b0;
              end else if (byte_idx != last_byte) begin
                byte_idx <= byte_idx + 1'b1;
                uart_tx  <= 1'b0;
              end else begin
                byte_idx <= '0;
                if (state == S_TRAILER) begin
                  state    <= S_DONE;
                  uart_tx  <= 1'b1;
                  bus.busy <= 1'b0;
                  bus.done <= 1'b1;
                end else if (bus.rd_addr != ADDR_LAST) begin
                  state       <= S_FETCH;
                  uart_tx     <= 1'b1;
                  bus.rd_en   <= 1'b1;
                  bus.rd_addr <= bus.rd_addr + 1'b1;
                end else if (next_ch[CH_W]) begin
                  state       <= S_FETCH;
                  uart_tx     <= 1'b1;
                  bus.rd_en   <= 1'b1;
                  bus.rd_ch   <= next_ch[CH_W-1:0];
                  bus.rd_addr <= '0;
                end else begin
                  state   <= S_TRAILER;
                  uart_tx <= 1'b0;
                end
              end
            end
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state   <= S_IDLE;
          uart_tx <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_waveform_uart_tx.sv
// Self-checking bench for waveform_uart_tx: buffer model, UART line decoder and a
// byte-stream reference model built directly from the record/trailer rules.
module tb_waveform_uart_tx;

  localparam int SW  = 14;
  localparam int NS  = 4;
  localparam int NC  = 2;
  localparam int CPB = 4;
  localparam int SB  = 3;
  localparam int TB  = (9 + SB) * CPB;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic uart_tx;

  waveform_uart_tx_if #(.SAMPLE_W(SW), .NUM_SAMPLES(NS), .NUM_CH(NC)) bus ();

  waveform_uart_tx #(
    .SAMPLE_W(SW), .NUM_SAMPLES(NS), .NUM_CH(NC), .CLKS_PER_BIT(CPB), .STOP_BITS(SB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .uart_tx(uart_tx)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Sample buffer: data appears one cycle after rd_en, junk otherwise.
  logic [SW-1:0] mem [NC][NS];
  int rd_cnt [NC];
  int cyc = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.rd_en === 1'b1) begin
      bus.rd_data           <= mem[bus.rd_ch][bus.rd_addr];
      rd_cnt[bus.rd_ch]     <= rd_cnt[bus.rd_ch] + 1;
    end else begin
      bus.rd_data <= SW'($urandom);
    end
  end

  // UART line decoder, sampling mid-bit on the falling clock edge.
  logic [7:0] rx_q [$];
  int         rx_t [$];
  int         n_starts      = 0;
  int         frame_err     = 0;
  int         last_push_cyc = 0;
  bit         dec_active    = 1'b0;
  bit         dec_ok;
  int         dec_off;
  int         dec_start;
  logic [7:0] dec_byte;
  always @(negedge clk) begin
    if (!rst_n) begin
      dec_active = 1'b0;
    end else if (!dec_active) begin
      if (uart_tx === 1'b0) begin
        dec_active = 1'b1;
        dec_off    = 0;
        dec_ok     = 1'b1;
        dec_byte   = 8'h00;
        dec_start  = cyc;
        n_starts++;
      end
    end else begin
      dec_off++;
      if (dec_off % CPB == CPB / 2) begin
        if (dec_off < CPB) begin
          if (uart_tx !== 1'b0) dec_ok = 1'b0;
        end else if (dec_off < 9 * CPB) begin
          dec_byte[dec_off / CPB - 1] = uart_tx;
        end else if (uart_tx !== 1'b1) begin
          dec_ok = 1'b0;
        end
      end
      if (dec_off == TB - 1) begin
        dec_active = 1'b0;
        if (dec_ok) begin
          rx_q.push_back(dec_byte);
          rx_t.push_back(dec_start);
          last_push_cyc = cyc;
        end else begin
          frame_err++;
        end
      end
    end
  end

  // Reference model: expected byte stream and transfer length for one unaborted transfer.
  logic [7:0] exp_q [$];
  int         exp_cycles;
  function automatic void build_model(input logic [NC-1:0] mask, input logic [15:0] wave);
    int idx;
    int e;
    logic [15:0] s;
    exp_q.delete();
    idx = 0;
    e   = 0;
    for (int c = 0; c < NC; c++) begin
      if (mask[c]) begin
        e++;
        for (int a = 0; a < NS; a++) begin
          idx = (idx + 1) % 65536;
          s   = 16'(mem[c][a]);
          exp_q.push_back(s[15:8]);
          exp_q.push_back(s[7:0]);
          exp_q.push_back(8'(idx));
        end
      end
    end
    exp_q.push_back(wave[15:8]);
    exp_q.push_back(wave[7:0]);
    exp_cycles = e * NS * (2 + 3 * TB) + 2 * TB + 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_random();
    for (int c = 0; c < NC; c++)
      for (int a = 0; a < NS; a++) mem[c][a] = SW'($urandom);
  endtask

  task automatic check_stream(input string tag, input int base, input int n_exp);
    int n_rec;
    int gap;
    n_rec = (exp_q.size() - 2) / 3;
    check({tag, " byte count"}, rx_q.size() - base, n_exp);
    for (int i = 0; i < n_exp && base + i < rx_q.size(); i++)
      check($sformatf("%s byte %0d", tag, i), 32'(rx_q[base + i]), 32'(exp_q[i]));
    for (int i = 0; i + 1 < n_exp && base + i + 1 < rx_t.size(); i++) begin
      gap = (i % 3 == 2 && i < 3 * n_rec - 1) ? TB + 2 : TB;
      check($sformatf("%s gap %0d", tag, i), rx_t[base + i + 1] - rx_t[base + i], gap);
    end
  endtask

  // One transfer: optional start spamming, optional abort a few cycles into byte #abort_after.
  task automatic run_xfer(input logic [NC-1:0] mask, input logic [15:0] wave, input bit spam,
                          input int abort_after, input int tail, output int base, output int act,
                          output int n_done, output int n_abort, output int end_cyc);
    int  s0;
    int  countdown;
    int  bad;
    bit  fin;
    bit  abort_fired;
    @(negedge clk);
    base = rx_q.size();
    s0   = n_starts;
    bus.ch_mask     = mask;
    bus.wave_number = wave;
    bus.start       = 1'b1;
    @(negedge clk);
    bus.start       = 1'b0;
    bus.ch_mask     = NC'($urandom);
    bus.wave_number = 16'($urandom);
    act = 0; n_done = 0; n_abort = 0; end_cyc = 0;
    countdown = -1; fin = 1'b0; abort_fired = 1'b0;
    for (int i = 0; i < 20000 && !fin; i++) begin
      bus.start = 1'b0;
      bus.abort = 1'b0;
      if (bus.busy || bus.done || bus.aborted) act++;
      if (bus.done) n_done++;
      if (bus.aborted) n_abort++;
      if (bus.done || bus.aborted) begin
        fin     = 1'b1;
        end_cyc = cyc;
      end else begin
        if (spam && (i % 97 == 5)) bus.start = 1'b1;
        if (abort_after > 0 && !abort_fired && countdown < 0 && n_starts - s0 >= abort_after)
          countdown = 10;
        if (countdown == 0) begin
          bus.abort   = 1'b1;
          abort_fired = 1'b1;
        end
        if (countdown >= 0) countdown--;
        @(negedge clk);
      end
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("transfer finished in budget", 32'(fin), 32'd1);
    bad = 0;
    for (int i = 0; i < tail; i++) begin
      @(negedge clk);
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.aborted !== 1'b0 || uart_tx !== 1'b1) bad++;
    end
    if (tail > 0) check("quiet after end", bad, 0);
  endtask

  initial begin
    int base, act, n_done, n_abort, end_cyc;
    int r0, r1;
    int s0;
    logic [NC-1:0] mask;
    logic [15:0]   wave;

    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.ch_mask = '0;
    bus.wave_number = '0;

    // Reset state
    #1 rst_n = 1'b0;
    #2;
    check("reset uart_tx", 32'(uart_tx), 32'd1);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset aborted", 32'(bus.aborted), 32'd0);
    check("reset rd_en", 32'(bus.rd_en), 32'd0);
    check("reset rd_ch", 32'(bus.rd_ch), 32'd0);
    check("reset rd_addr", 32'(bus.rd_addr), 32'd0);
    #24 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle line", 32'(uart_tx), 32'd1);

    // Scenario 1: directed buffer, both channels
    mem[0][0] = 14'h0001; mem[0][1] = 14'h1FFF; mem[0][2] = 14'h2ABC; mem[0][3] = 14'h3FFF;
    for (int a = 0; a < NS; a++) mem[1][a] = SW'(16'h0010 + a);
    build_model(2'b11, 16'hBEEF);
    r0 = rd_cnt[0]; r1 = rd_cnt[1];
    run_xfer(2'b11, 16'hBEEF, 1'b0, 0, 20, base, act, n_done, n_abort, end_cyc);
    check_stream("s1", base, exp_q.size());
    check("s1 clocks", act, exp_cycles);
    check("s1 done pulses", n_done, 1);
    check("s1 aborted pulses", n_abort, 0);
    check("s1 reads ch0", rd_cnt[0] - r0, NS);
    check("s1 reads ch1", rd_cnt[1] - r1, NS);

    // Scenario 2: channel 1 only
    build_model(2'b10, 16'hBEEF);
    r0 = rd_cnt[0]; r1 = rd_cnt[1];
    run_xfer(2'b10, 16'hBEEF, 1'b0, 0, 10, base, act, n_done, n_abort, end_cyc);
    check_stream("s2", base, exp_q.size());
    check("s2 clocks", act, exp_cycles);
    check("s2 reads ch0", rd_cnt[0] - r0, 0);
    check("s2 reads ch1", rd_cnt[1] - r1, NS);

    // Scenario 3: empty mask sends only the trailer
    build_model(2'b00, 16'h1234);
    r0 = rd_cnt[0]; r1 = rd_cnt[1];
    run_xfer(2'b00, 16'h1234, 1'b0, 0, 10, base, act, n_done, n_abort, end_cyc);
    check_stream("s3", base, exp_q.size());
    check("s3 clocks", act, exp_cycles);
    check("s3 done pulses", n_done, 1);
    check("s3 no reads", (rd_cnt[0] - r0) + (rd_cnt[1] - r1), 0);

    // Scenario 6: start spammed while busy changes nothing
    build_model(2'b11, 16'hBEEF);
    run_xfer(2'b11, 16'hBEEF, 1'b1, 0, 60, base, act, n_done, n_abort, end_cyc);
    check_stream("s6", base, exp_q.size());
    check("s6 clocks", act, exp_cycles);
    check("s6 done pulses", n_done, 1);

    // Scenario 5: asynchronous reset during a low data bit of the first byte
    @(negedge clk);
    s0 = n_starts;
    bus.ch_mask = 2'b11; bus.wave_number = 16'h5A5A; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 200 && n_starts == s0; i++) @(negedge clk);
    check("s5 frame started", 32'(n_starts - s0), 32'd1);
    repeat (2 * CPB + 1) @(negedge clk);
    @(posedge clk);
    #1;
    check("s5 line low in data bit", 32'(uart_tx), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    check("s5 async uart_tx", 32'(uart_tx), 32'd1);
    check("s5 async busy", 32'(bus.busy), 32'd0);
    check("s5 async rd_en", 32'(bus.rd_en), 32'd0);
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    fill_random();
    mask = NC'($urandom_range(1, 3));
    wave = 16'($urandom);
    build_model(mask, wave);
    run_xfer(mask, wave, 1'b0, 0, 10, base, act, n_done, n_abort, end_cyc);
    check_stream("s5 after reset", base, exp_q.size());
    check("s5 clocks", act, exp_cycles);

    // Scenario 4: abort in the middle of byte 1 of record 2, then immediate restart
    fill_random();
    wave = 16'($urandom);
    build_model(2'b11, wave);
    run_xfer(2'b11, wave, 1'b0, 5, 0, base, act, n_done, n_abort, end_cyc);
    check_stream("s4 abort", base, 5);
    check("s4 aborted pulses", n_abort, 1);
    check("s4 done pulses", n_done, 0);
    check("s4 abort after stop bits", end_cyc - last_push_cyc, 1);
    check("s4 busy low with aborted", 32'(bus.busy), 32'd0);
    check("s4 line high", 32'(uart_tx), 32'd1);
    mask = 2'b01;
    wave = 16'($urandom);
    build_model(mask, wave);
    run_xfer(mask, wave, 1'b0, 0, 10, base, act, n_done, n_abort, end_cyc);
    check_stream("s4 restart", base, exp_q.size());
    check("s4 restart clocks", act, exp_cycles);
    check("s4 restart done", n_done, 1);

    // Randomized transfers
    for (int t = 0; t < 3; t++) begin
      fill_random();
      mask = NC'($urandom);
      wave = 16'($urandom);
      build_model(mask, wave);
      run_xfer(mask, wave, 1'b0, 0, 5, base, act, n_done, n_abort, end_cyc);
      check_stream($sformatf("rand%0d", t), base, exp_q.size());
      check($sformatf("rand%0d clocks", t), act, exp_cycles);
      check($sformatf("rand%0d done", t), n_done, 1);
    end

    check("framing errors", frame_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
